// File: rtl/regfile_2r1w.sv
// Parametrised register file: DEPTH x WIDTH flops, one synchronous write port,
// two combinational read ports, optional hardwired-zero reg 0 and write bypass.
module regfile_2r1w #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A write only lands when it targets real, writable storage and reset is low;
  // the same qualifier gates the bypass so a dropped write is never forwarded.
  assign wr_ok = we && !reset && in_range(waddr) && !is_zero_reg(waddr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (in_range(raddr_a) && !is_zero_reg(raddr_a)) begin
      if ((BYPASS != 0) && wr_ok && (raddr_a == waddr)) rdata_a = wdata;
      else rdata_a = regs[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (in_range(raddr_b) && !is_zero_reg(raddr_b)) begin
      if ((BYPASS != 0) && wr_ok && (raddr_b == waddr)) rdata_b = wdata;
      else rdata_b = regs[raddr_b];
    end
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file generalising the team's single 4-bit write-enabled register into DEPTH registers of WIDTH bits, with one write port and two independent read ports. It is the CPU datapath's architectural register storage: operand reads (rs1/rs2) are served combinationally and the writeback stage writes on the rising clock edge. Optional hardwired-zero register 0 and optional write-to-read bypass are set by parameters.

## Interface
- WIDTH, 8: bits per register (≥1).
- DEPTH, 8: number of registers (≥2; need not be a power of two).
- AW, $clog2(DEPTH): address width, derived; not overridden by instantiators.
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage.
- BYPASS, 1: 1 = a same-cycle write to the read address is forwarded to rdata; 0 = reads return stored contents only.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high; clears every register to 0.
- we  input  1  write enable, sampled on the rising edge of clk.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  AW  read address, port A.
- rdata_a  output  WIDTH  read data, port A (combinational).
- raddr_b  input  AW  read address, port B.
- rdata_b  output  WIDTH  read data, port B (combinational).

## Operation
- Storage: DEPTH × WIDTH flops; no memory macro.
- Write: on rising clk with reset low and we=1, reg[waddr] <= wdata. With we=0, all registers hold.
- Write suppressed when waddr ≥ DEPTH, or when ZERO_REG=1 and waddr=0.
- Read, per port independently: rdata = 0 when raddr ≥ DEPTH; else 0 when ZERO_REG=1 and raddr=0; else wdata when BYPASS=1, we=1, reset=0 and raddr==waddr (and that write is not suppressed); else reg[raddr].
- Ports A and B may address the same register; both return the same value.
- Reset asserted: all registers read 0 immediately. Bypass is disabled while reset is high, so both rdata read 0 for any in-range address.
- No internal state beyond the register array.

## Timing
- Reset: asynchronous assert, taking effect without a clock edge. All registers go to 0, so rdata_a = rdata_b = 0. Deassertion is synchronous to clk from the system's point of view; the first write can occur on the first rising edge after deassertion.
- Read latency: 0 cycles (combinational from raddr and stored state).
- Write-to-read latency:
  - BYPASS=1: visible in the same cycle, combinationally, as soon as we, waddr and wdata are stable.
  - BYPASS=0: visible after the rising edge that commits the write.
- Write and reset together: reset wins and the write is lost.
- Back-to-back writes to one address on consecutive edges: the last write wins. No hazards beyond those handled by bypass.
- No handshake; the block never stalls.

## Test plan
- Reset: load reg3=8'hA5, then assert reset mid-cycle (no clk edge) -> rdata_a (raddr_a=3) drops to 8'h00 immediately. Every address reads 0 after reset.
- Write/hold (BYPASS=0): we=1, waddr=5, wdata=8'h3C, edge -> rdata_a(5)=8'h3C. Then we=0, wdata=8'hFF, edge -> still 8'h3C. Then we=1, wdata=8'h11, edge -> 8'h11.
- Dual read: reg2=8'h12 and reg7=8'hEF. raddr_a=2, raddr_b=7 -> 8'h12 and 8'hEF. Both ports at 7 -> both 8'hEF.
- Bypass (BYPASS=1): reg4=8'h01. Before the edge, drive we=1, waddr=4, wdata=8'h99 with raddr_a=4 -> rdata_a=8'h99 at once. raddr_b=3 is unaffected. After the edge reg4 holds 8'h99.
- Zero register (ZERO_REG=1): we=1, waddr=0, wdata=8'h77, edge -> rdata_a(0)=8'h00. This holds with bypass too. With ZERO_REG=0, the same stimulus reads 8'h77.
- Out-of-range (DEPTH=6, AW=3): we=1, waddr=6, wdata=8'hAA -> no register changes, and raddr_a=6 or 7 reads 8'h00. Also verify reset asserted together with a write to reg1: reg1 stays 8'h00.
